cpld_ram_arbiter: RTL and testbench
===================================

CPLD_RAM_ARBITER -- requirements
Module: cpld_ram_arbiter

Interface
REQ-001 The module SHALL have these ports, one per line: name, direction, width, meaning; clock and reset first.
- clk  input  1  CPU clock, 4 MHz; all state on posedge.
- reset_b  input  1  one clock; reset is asynchronous and active-low.
- mreq_b, iorq_b, rfsh_b, rd_b, wr_b  input  1 each  Z80 bus strobes, active-low.
- ready  input  1  Z80 wait line; high = no wait.
- adr15, adr14  input  1 each  CPU address top bits.
- bank_sel  input  6  current cccbbb bank/scheme value from the config register.
- ld_req  input  1  loader requests one RAM access; held until ld_ack.
- ld_blk  input  5  loader 16K block number.
- ld_we  input  1  loader access is a write (1) or read (0).
- ld_ack  output  1  one-cycle pulse; loader access completed.
- ld_sel  output  1  steers external address/data muxes to the loader.
- ramcs_b, ramoe_b, ramwe_b  output  1 each  expansion SRAM strobes, active-low.
- ramadrhi  output  5  SRAM address bits 18:14.
- ramdis  output  1  disables internal CPC RAM.
- err  output  1  sticky wait-timeout flag.
REQ-002 The module SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of consecutive ready-low cycles tolerated in a CPU write.

Function
REQ-003 The FSM SHALL have states IDLE, CPU_RD, CPU_WR0, CPU_WR1, LD_ACC, LD_END; encoding is free.
REQ-004 A CPU cycle SHALL start on the posedge where mreq_b is sampled low after being high the previous posedge, with rfsh_b=1 and iorq_b=1.
REQ-005 CPU mapping SHALL be decoded from bank_sel={c[2:0],b[2:0]} and {adr15,adr14}=q:
- b=0: unmapped.
- b=1: q=11 maps to {c,11}.
- b=2: all q map to {c,q}.
- b=3: q=11 maps to {c,11}.
- b=4..7: q=01 maps to {c,b-4}.
- All other cases are unmapped.
REQ-006 For a mapped CPU cycle, IDLE SHALL go to CPU_RD if rd_b=0, else CPU_WR0; an unmapped cycle SHALL stay in IDLE with all strobes inactive.
REQ-007 In CPU_RD: ramcs_b=0, ramoe_b=0, ramdis=1, ramadrhi=mapped block; return to IDLE when mreq_b is sampled high.
REQ-008 In CPU_WR0:
- Drive ramcs_b=0 and ramdis=1.
- Drive ramwe_b=wr_b, gated low only while ready=1.
- Go to CPU_WR1 when ready=1.
- Each ready=0 cycle increments a 4-bit wait counter.
REQ-009 When the wait counter reaches WAIT_MAX, the FSM SHALL set err, deassert all strobes and return to IDLE.
REQ-010 CPU_WR1 SHALL deassert ramwe_b, hold ramcs_b low for one cycle and go to IDLE; the wait counter SHALL clear on entering IDLE.
REQ-011 A loader grant SHALL occur only from IDLE on a posedge with mreq_b=0, rfsh_b=0 and ld_req=1, which enters LD_ACC.
REQ-012 In LD_ACC:
- Drive ld_sel=1, ramcs_b=0, ramadrhi=ld_blk and ramdis=0.
- Drive ramwe_b=0 if ld_we, else ramoe_b=0.
- Next state is LD_END.
REQ-013 LD_END SHALL deassert ramwe_b and ramoe_b, keep ld_sel=1, pulse ld_ack for exactly one cycle, then go to IDLE.
REQ-014 If mreq_b is sampled high during LD_ACC (refresh slot ended), the FSM SHALL abort to IDLE with no ld_ack; ld_req stays pending and is retried at the next refresh slot.
REQ-015 CPU cycles SHALL always have priority, and the loader SHALL never be granted outside a refresh slot.
REQ-016 If ld_req falls before a grant, no access SHALL occur.
REQ-017 ld_sel SHALL be 0 in every CPU state; ld_sel=1 and ramdis=1 SHALL never coincide.
REQ-018 A bank_sel change mid-cycle SHALL NOT alter ramadrhi until the next cycle start; ramadrhi is latched at the start of each cycle.
REQ-019 err SHALL clear only on reset.

Reset
REQ-020 While reset_b=0, the module SHALL immediately (asynchronously) force: state=IDLE, ramcs_b=1, ramoe_b=1, ramwe_b=1, ramdis=0, ld_ack=0, ld_sel=0, ramadrhi=0, err=0, wait counter=0.
REQ-021 Reset asserted mid-access SHALL abort the access without emitting ld_ack.

Verification
REQ-022 Directed scenarios the bench SHALL cover:
- bank_sel=6'b001010, CPU read at 0x8000 -> CPU_RD, ramadrhi=5'b00110, ramoe_b=0, ramdis=1.
- bank_sel=6'b000001, CPU write at 0x4000 -> unmapped; ramcs_b stays 1, ramdis stays 0.
- bank_sel=6'b011101, write at 0x4000 with ready low 3 cycles -> ramwe_b low only after ready=1, block 5'b01101, wait counter=3 at CPU_WR1.
- ld_req=1, ld_blk=31, ld_we=1, M1 refresh slot -> ramadrhi=31, ramwe_b low for 1 cycle, ld_ack one cycle later, no ramdis.
- ld_req=1 during CPU read -> no grant until the next refresh slot; a slot cut short in LD_ACC gives no ack and a retry succeeds.
- ready held low 15 cycles in a CPU write -> err=1, strobes high, IDLE; reset_b pulse clears err.

Source files
------------

// File: rtl/cpld_ram_arbiter.sv
// Expansion SRAM arbiter: maps Z80 memory cycles onto banked SRAM and lets a
// loader steal the bus during M1 refresh slots.
module cpld_ram_arbiter #(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       mreq_b,
   input  logic       iorq_b,
   input  logic       rfsh_b,
   input  logic       rd_b,
   input  logic       wr_b,
   input  logic       ready,
   input  logic       adr15,
   input  logic       adr14,
   input  logic [5:0] bank_sel,
   input  logic       ld_req,
   input  logic [4:0] ld_blk,
   input  logic       ld_we,
   output logic       ld_ack,
   output logic       ld_sel,
   output logic       ramcs_b,
   output logic       ramoe_b,
   output logic       ramwe_b,
   output logic [4:0] ramadrhi,
   output logic       ramdis,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CPU_RD  = 3'd1,
      CPU_WR0 = 3'd2,
      CPU_WR1 = 3'd3,
      LD_ACC  = 3'd4,
      LD_END  = 3'd5
   } state_t;

   state_t     state_r;
   logic       mreq_prev_r;
   logic [3:0] wait_cnt_r;
   logic [5:0] map_s;
   logic       cpu_start_s;
   logic       ld_grant_s;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

   // Returns {mapped, block}; bit 5 set when the quadrant q lands in SRAM.
   function automatic logic [5:0] cpu_map(input logic [5:0] sel, input logic [1:0] q);
      logic [2:0] c;
      logic [2:0] b;
      logic [5:0] res;
      c   = sel[5:3];
      b   = sel[2:0];
      res = 6'b000000;
      case (b)
         3'd0: res = 6'b000000;
         3'd1, 3'd3: begin
            if (q == 2'b11) res = {1'b1, c, 2'b11};
            else            res = 6'b000000;
         end
         3'd2: res = {1'b1, c, q};
         default: begin
            if (q == 2'b01) res = {1'b1, c, b[1:0]};
            else            res = 6'b000000;
         end
      endcase
      return res;
   endfunction

   assign map_s       = cpu_map(bank_sel, {adr15, adr14});
   assign cpu_start_s = ~mreq_b & mreq_prev_r & rfsh_b & iorq_b;
   assign ld_grant_s  = ~mreq_b & ~rfsh_b & ld_req;

   // Arbitration FSM with all strobes registered for the state being entered.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_r     <= IDLE;
         mreq_prev_r <= 1'b1;
         wait_cnt_r  <= 4'd0;
         ramcs_b     <= 1'b1;
         ramoe_b     <= 1'b1;
         ramwe_b     <= 1'b1;
         ramdis      <= 1'b0;
         ld_ack      <= 1'b0;
         ld_sel      <= 1'b0;
         ramadrhi    <= 5'd0;
         err         <= 1'b0;
      end else begin
         mreq_prev_r <= mreq_b;
         ld_ack      <= 1'b0;
         case (state_r)
            IDLE: begin
               wait_cnt_r <= 4'd0;
               ramcs_b    <= 1'b1;
               ramoe_b    <= 1'b1;
               ramwe_b    <= 1'b1;
               ramdis     <= 1'b0;
               ld_sel     <= 1'b0;
               // CPU cycles are checked first so they always win
               if (cpu_start_s) begin
                  if (map_s[5]) begin
                     ramadrhi <= map_s[4:0];
                     ramcs_b  <= 1'b0;
                     ramdis   <= 1'b1;
                     if (!rd_b) begin
                        state_r <= CPU_RD;
                        ramoe_b <= 1'b0;
                     end else begin
                        state_r <= CPU_WR0;
                     end
                  end else begin
                     state_r <= IDLE;
                  end
               end else if (ld_grant_s) begin
                  state_r  <= LD_ACC;
                  ld_sel   <= 1'b1;
                  ramcs_b  <= 1'b0;
                  ramadrhi <= ld_blk;
                  ramwe_b  <= ~ld_we;
                  ramoe_b  <= ld_we;
               end else begin
                  state_r <= IDLE;
               end
            end
            CPU_RD: begin
               if (mreq_b) begin
                  state_r <= IDLE;
                  ramcs_b <= 1'b1;
                  ramoe_b <= 1'b1;
                  ramdis  <= 1'b0;
               end else begin
                  state_r <= CPU_RD;
               end
            end
            CPU_WR0: begin
               if (ready) begin
                  state_r <= CPU_WR1;
                  ramwe_b <= wr_b;
               end else if (wait_cnt_r == WAIT_LAST) begin
                  err        <= 1'b1;
                  state_r    <= IDLE;
                  wait_cnt_r <= 4'd0;
                  ramcs_b    <= 1'b1;
                  ramoe_b    <= 1'b1;
                  ramwe_b    <= 1'b1;
                  ramdis     <= 1'b0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 4'd1;
                  ramwe_b    <= 1'b1;
               end
            end
            CPU_WR1: begin
               state_r    <= IDLE;
               wait_cnt_r <= 4'd0;
               ramcs_b    <= 1'b1;
               ramwe_b    <= 1'b1;
               ramdis     <= 1'b0;
            end
            LD_ACC: begin
               // Refresh slot ended early: drop the access, request stays pending
               if (mreq_b) begin
                  state_r <= IDLE;
                  ld_sel  <= 1'b0;
               end else begin
                  state_r <= LD_END;
                  ld_ack  <= 1'b1;
               end
               ramcs_b <= 1'b1;
               ramoe_b <= 1'b1;
               ramwe_b <= 1'b1;
            end
            LD_END: begin
               state_r <= IDLE;
               ld_sel  <= 1'b0;
            end
            default: begin
               state_r    <= IDLE;
               wait_cnt_r <= 4'd0;
               ramcs_b    <= 1'b1;
               ramoe_b    <= 1'b1;
               ramwe_b    <= 1'b1;
               ramdis     <= 1'b0;
               ld_sel     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpld_ram_arbiter.sv
// Directed plus randomized bench for cpld_ram_arbiter; expectations come from a
// bank-rule model and a simple bus-phase view of each access.
`timescale 1ns/1ps
module tb_cpld_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset_b;
   logic       mreq_b, iorq_b, rfsh_b, rd_b, wr_b, ready;
   logic       adr15, adr14;
   logic [5:0] bank_sel;
   logic       ld_req, ld_we;
   logic [4:0] ld_blk;
   logic       ld_ack, ld_sel, ramcs_b, ramoe_b, ramwe_b, ramdis, err;
   logic [4:0] ramadrhi;

   int         total = 0;
   int         bad = 0;
   logic [4:0] m_adr = 5'd0;
   logic       m_err = 1'b0;

   localparam int WAIT_MAX = 15;

   cpld_ram_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .iorq_b(iorq_b),
      .rfsh_b(rfsh_b), .rd_b(rd_b), .wr_b(wr_b), .ready(ready),
      .adr15(adr15), .adr14(adr14), .bank_sel(bank_sel), .ld_req(ld_req),
      .ld_blk(ld_blk), .ld_we(ld_we), .ld_ack(ld_ack), .ld_sel(ld_sel),
      .ramcs_b(ramcs_b), .ramoe_b(ramoe_b), .ramwe_b(ramwe_b),
      .ramadrhi(ramadrhi), .ramdis(ramdis), .err(err)
   );

   always #125 clk = ~clk;

   // Bank rules written as block arithmetic: block = 4*c + offset
   function automatic logic [5:0] ref_map(input logic [5:0] bs, input logic [1:0] q);
      int  c, b, blk;
      bit  hit;
      c = int'(bs[5:3]);
      b = int'(bs[2:0]);
      hit = 1'b0;
      blk = 0;
      if (b == 2) begin
         hit = 1'b1; blk = c * 4 + int'(q);
      end else if ((b == 1 || b == 3) && q == 2'b11) begin
         hit = 1'b1; blk = c * 4 + 3;
      end else if (b >= 4 && q == 2'b01) begin
         hit = 1'b1; blk = c * 4 + (b - 4);
      end
      return {hit, 5'(blk)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input bit cs, input bit oe, input bit we,
                          input bit dis, input bit sel, input bit ack);
      logic [11:0] o, e;
      o = {ramcs_b, ramoe_b, ramwe_b, ramdis, ld_sel, ld_ack, err, ramadrhi};
      e = {cs, oe, we, dis, sel, ack, m_err, m_adr};
      chk(tag, 32'(o), 32'(e));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cpu_read(input logic [5:0] bs, input logic [1:0] q);
      logic [5:0] m;
      m = ref_map(bs, q);
      bank_sel = bs; {adr15, adr14} = q; mreq_b = 1'b0; rd_b = 1'b0;
      step();
      if (m[5]) begin
         m_adr = m[4:0];
         chk_out("rd_start", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         bank_sel = 6'($urandom);
         step();
         chk_out("rd_hold", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
         chk_out("rd_unmapped", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      mreq_b = 1'b1; rd_b = 1'b1;
      step();
      chk_out("rd_end", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cpu_write(input logic [5:0] bs, input logic [1:0] q, input int n);
      logic [5:0] m;
      m = ref_map(bs, q);
      bank_sel = bs; {adr15, adr14} = q; mreq_b = 1'b0; rd_b = 1'b1; wr_b = 1'b1; ready = 1'b1;
      step();
      if (!m[5]) begin
         chk_out("wr_unmapped", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         wr_b = 1'b0;
         step();
         chk_out("wr_unmapped2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         mreq_b = 1'b1; wr_b = 1'b1;
         step();
         chk_out("wr_unmapped_end", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         return;
      end
      m_adr = m[4:0];
      chk_out("wr_start", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      wr_b = 1'b0;
      for (int i = 0; i < n; i++) begin
         ready = 1'b0;
         step();
         if (i + 1 == WAIT_MAX) begin
            m_err = 1'b1;
            chk_out("wr_timeout", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            mreq_b = 1'b1; wr_b = 1'b1; ready = 1'b1;
            step();
            chk_out("wr_timeout_idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            return;
         end
         chk_out("wr_wait", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      ready = 1'b1;
      step();
      chk_out("wr_pulse", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("wr_waitcnt", 32'(dut.wait_cnt_r), 32'(n));
      mreq_b = 1'b1; wr_b = 1'b1;
      step();
      chk_out("wr_end", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ld_slot(input logic [4:0] blk, input bit we, input bit cut, input bit req);
      ld_blk = blk; ld_we = we; ld_req = req; rfsh_b = 1'b0; mreq_b = 1'b0;
      step();
      if (!req) begin
         chk_out("ld_noreq", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         mreq_b = 1'b1; rfsh_b = 1'b1;
         step();
         chk_out("ld_noreq_end", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         return;
      end
      m_adr = blk;
      chk_out("ld_acc", 1'b0, we, !we, 1'b0, 1'b1, 1'b0);
      if (cut) begin
         mreq_b = 1'b1; rfsh_b = 1'b1;
         step();
         chk_out("ld_abort", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         return;
      end
      step();
      chk_out("ld_end", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      ld_req = 1'b0; mreq_b = 1'b1; rfsh_b = 1'b1;
      step();
      chk_out("ld_idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_b = 1'b0; mreq_b = 1'b1; iorq_b = 1'b1; rfsh_b = 1'b1; rd_b = 1'b1;
      wr_b = 1'b1; ready = 1'b1; adr15 = 1'b0; adr14 = 1'b0; bank_sel = 6'd0;
      ld_req = 1'b0; ld_blk = 5'd0; ld_we = 1'b0;
      step();
      chk_out("reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      reset_b = 1'b1;
      step();
      chk_out("post_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      cpu_read(6'b001010, 2'b10);
      chk("rd_block", 32'(ramadrhi), 32'(5'b00110));
      cpu_write(6'b000001, 2'b01, 0);
      cpu_write(6'b011101, 2'b01, 3);
      chk("wr_block", 32'(ramadrhi), 32'(5'b01101));
      ld_slot(5'd31, 1'b1, 1'b0, 1'b1);

      // Loader pending across a CPU read, then a short slot, then a retry
      ld_req = 1'b1; ld_blk = 5'd9; ld_we = 1'b0;
      cpu_read(6'b000010, 2'b00);
      ld_slot(5'd9, 1'b0, 1'b1, 1'b1);
      step();
      chk_out("ld_pending_idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ld_slot(5'd9, 1'b0, 1'b0, 1'b1);

      // Request withdrawn before any refresh slot
      ld_req = 1'b1;
      step();
      chk_out("ld_no_slot", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ld_slot(5'd3, 1'b1, 1'b0, 1'b0);

      cpu_write(6'b000010, 2'b11, WAIT_MAX);
      cpu_read(6'b000110, 2'b01);
      reset_b = 1'b0;
      #1;
      m_err = 1'b0; m_adr = 5'd0;
      chk_out("err_cleared", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_b = 1'b1;
      step();

      // Reset arriving in the middle of a loader access
      ld_blk = 5'd20; ld_we = 1'b1; ld_req = 1'b1; rfsh_b = 1'b0; mreq_b = 1'b0;
      step();
      m_adr = 5'd20;
      chk_out("mid_acc", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      #10 reset_b = 1'b0;
      #1;
      m_adr = 5'd0;
      chk_out("mid_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_b = 1'b1; ld_req = 1'b0; mreq_b = 1'b1; rfsh_b = 1'b1;
      step();
      chk_out("mid_reset_noack", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 3))
            0: cpu_read(6'($urandom), 2'($urandom));
            1: cpu_write(6'($urandom), 2'($urandom), int'($urandom_range(0, 6)));
            2: ld_slot(5'($urandom), 1'($urandom), 1'b0, 1'b1);
            default: begin
               ld_slot(5'($urandom), 1'($urandom), 1'b1, 1'b1);
               ld_req = 1'b0;
               step();
               chk_out("rnd_drop", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
